mac_sequencer: RTL and testbench
================================

# mac_sequencer

Sequencer for the tap-multiplexed multiply-accumulate datapath. Accepts one input sample per valid/ready handshake, steps the tap mux through all NTAPS taps while controlling accumulator clear/enable, captures the finished sum into the output register, and presents it on a valid/ready output handshake with backpressure. Replaces the free-running 4-state tap controller so that the datapath only runs when a sample is present and a result slot is available.

## Interface

- NTAPS, 4, number of taps per sample; legal range 2..256; select width SELW = $clog2(NTAPS) is derived, not overridable
- ph1  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on ph1 rising edge
- in_valid  in  1  upstream sample available
- in_ready  out  1  sequencer can accept a sample
- dataClk1  out  1  input sample register / delay-line load enable
- muxControl  out  SELW  tap select to coefficient/sample mux
- accumEn  out  1  accumulator update enable
- clearAccum  out  1  accumulator loads the product instead of adding it
- outLoad  out  1  capture accumulator into output register
- out_valid  out  1  output register holds an unconsumed result
- out_ready  in  1  downstream consumes result
- busy  out  1  state is not IDLE

## Operation

- States: IDLE, RUN, CAPT. Registers: state, tap counter (SELW bits), out_valid.
- Reset (reset==0 at an edge): state=IDLE, tap=0, out_valid=0. While reset is low, every output is 0, in_ready included.
- IDLE: in_ready=1. Handshake fire = in_valid & in_ready. On fire: dataClk1=1 in the same cycle, tap<=0, next state RUN. Otherwise stay in IDLE with dataClk1=0.
- RUN: muxControl=tap, accumEn=1, clearAccum=(tap==0).
  - tap<NTAPS-1: tap<=tap+1, stay in RUN.
  - tap==NTAPS-1: tap<=0, next state CAPT.
- CAPT: outLoad = ~out_valid | out_ready.
  - outLoad==1: next state IDLE.
  - outLoad==0: stay in CAPT (stall). Accumulator holds its value (accumEn=0).
- out_valid next value: 1 if outLoad; else 0 if out_ready; else hold. A cycle with outLoad and out_ready both high replaces the result and keeps out_valid=1.
- Outputs not listed for a state are 0. muxControl=0 outside RUN.
- busy = (state != IDLE).
- in_valid outside IDLE is ignored; no sample is ever dropped once in_ready was seen high with in_valid.
- Illegal state encoding: next state IDLE, all outputs 0.
- Reset mid-operation aborts the sample: no outLoad, out_valid cleared, and the accumulator contents are don't-care.

## Timing

- Sample accepted in cycle 0 (IDLE, fire): dataClk1 high in cycle 0.
- Cycles 1..NTAPS: RUN with muxControl = 0..NTAPS-1. clearAccum is high only in cycle 1.
- Cycle NTAPS+1: CAPT; outLoad is high if the output slot is free.
- out_valid rises at cycle NTAPS+2, which is also the earliest next IDLE.
- Maximum throughput: one sample per NTAPS+2 cycles. For NTAPS=4, that is 6 cycles.
- Each CAPT stall cycle adds one cycle to the latency.
- All outputs except in_ready, dataClk1 and outLoad are functions of registered state only. in_ready and dataClk1 depend on state and in_valid. outLoad depends on state, out_valid and out_ready.

## Test plan

- Reset: hold reset=0 for 3 cycles with in_valid=1 -> all outputs 0. Release -> in_ready=1, busy=0, out_valid=0.
- Single sample, NTAPS=4, out_ready=1: in_valid pulse at cycle 0 -> dataClk1 at cycle 0; muxControl 0,1,2,3 in cycles 1-4; clearAccum only in cycle 1; outLoad at cycle 5; out_valid=1 at cycle 6, then 0 at cycle 7.
- Back-to-back: in_valid held high for 3 samples, out_ready=1 -> fires at cycles 0, 6 and 12; three outLoad pulses; in_ready low in every non-IDLE cycle.
- Backpressure: out_ready=0, two samples sent -> first result out_valid=1; second sample stalls in CAPT (outLoad=0, busy=1). Raise out_ready -> outLoad in the same cycle, out_valid stays 1, next state IDLE.
- Reset mid-RUN: assert reset while muxControl=2 -> next cycle state IDLE, out_valid=0, no outLoad pulse; a following sample sequences normally from tap 0.
- NTAPS=5 build: one sample -> muxControl 0..4 with SELW=3; out_valid at cycle 7.

Source files
------------

// File: rtl/mac_sequencer.sv
// Sequencer for the tap-multiplexed MAC datapath: one sample per
// in handshake, NTAPS tap steps, result capture on an out handshake.
//
// Ports:
//   ph1        clock
//   reset      sync active-low reset
//   in_valid   upstream sample available
//   in_ready   sample can be accepted
//   dataClk1   sample register load enable
//   muxControl tap select
//   accumEn    accumulator update enable
//   clearAccum accumulator loads product
//   outLoad    capture sum into output reg
//   out_valid  output reg holds a result
//   out_ready  downstream consumes result
//   busy       sequencer not idle
module mac_sequencer #(
  parameter  int NTAPS = 4,
  localparam int SELW  = $clog2(NTAPS)
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            dataClk1,
  output logic [SELW-1:0] muxControl,
  output logic            accumEn,
  output logic            clearAccum,
  output logic            outLoad,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam logic [SELW-1:0] LAST =
    SELW'(NTAPS - 1);

  state_t          state, state_n;
  logic [SELW-1:0] tap, tap_n;
  logic            ov_q, ov_n;

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state <= IDLE;
      tap   <= '0;
      ov_q  <= 1'b0;
    end else begin
      state <= state_n;
      tap   <= tap_n;
      ov_q  <= ov_n;
    end
  end

  // Outputs are all forced low while reset
  // is held, so the gating lives here.
  always_comb begin
    in_ready   = 1'b0;
    dataClk1   = 1'b0;
    muxControl = '0;
    accumEn    = 1'b0;
    clearAccum = 1'b0;
    outLoad    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    state_n    = IDLE;
    tap_n      = tap;
    if (reset) begin
      unique case (state)
        IDLE: begin
          in_ready  = 1'b1;
          dataClk1  = in_valid;
          out_valid = ov_q;
          if (in_valid) begin
            tap_n   = '0;
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
        RUN: begin
          muxControl = tap;
          accumEn    = 1'b1;
          clearAccum = (tap == '0);
          out_valid  = ov_q;
          busy       = 1'b1;
          if (tap == LAST) begin
            tap_n   = '0;
            state_n = CAPT;
          end else begin
            tap_n   = tap + SELW'(1);
            state_n = RUN;
          end
        end
        CAPT: begin
          // Capture only when the slot is
          // free or being drained now.
          outLoad   = ~ov_q | out_ready;
          out_valid = ov_q;
          busy      = 1'b1;
          state_n   = outLoad ? IDLE : CAPT;
        end
        default: begin
          state_n = IDLE;
          tap_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    if (outLoad)
      ov_n = 1'b1;
    else if (out_ready)
      ov_n = 1'b0;
    else
      ov_n = ov_q;
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer (NTAPS=4 and NTAPS=5).
// Driver queues expected outputs; negedge monitor compares.
module tb_mac_sequencer;

  logic ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  logic       rst4 = 1'b0, iv4 = 1'b1, or4 = 1'b1;
  logic       ir4, dc4, ae4, ca4, ol4, ov4, bz4;
  logic [1:0] mx4;

  logic       rst5 = 1'b0, iv5 = 1'b0, or5 = 1'b1;
  logic       ir5, dc5, ae5, ca5, ol5, ov5, bz5;
  logic [2:0] mx5;

  mac_sequencer #(.NTAPS(4)) dut4 (
    .ph1(ph1), .reset(rst4),
    .in_valid(iv4), .in_ready(ir4),
    .dataClk1(dc4), .muxControl(mx4),
    .accumEn(ae4), .clearAccum(ca4),
    .outLoad(ol4), .out_valid(ov4),
    .out_ready(or4), .busy(bz4)
  );

  mac_sequencer #(.NTAPS(5)) dut5 (
    .ph1(ph1), .reset(rst5),
    .in_valid(iv5), .in_ready(ir5),
    .dataClk1(dc5), .muxControl(mx5),
    .accumEn(ae5), .clearAccum(ca5),
    .outLoad(ol5), .out_valid(ov5),
    .out_ready(or5), .busy(bz5)
  );

  typedef struct {
    logic [9:0] e;
    string      n;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // {in_ready,dataClk1,mux[2:0],accumEn,
  //  clearAccum,outLoad,out_valid,busy}
  function automatic logic [9:0] E(
    bit ir, bit dc, logic [2:0] m, bit ae,
    bit ca, bit ol, bit ov, bit bz);
    return {ir, dc, m, ae, ca, ol, ov, bz};
  endfunction

  task automatic step(
    input int d, input bit r, input bit iv,
    input bit ordy, input logic [9:0] e,
    input string n);
    exp_t x;
    @(posedge ph1);
    #1;
    if (d == 0) begin
      rst4 = r; iv4 = iv; or4 = ordy;
      x.e = e; x.n = n;
      q4.push_back(x);
    end else begin
      rst5 = r; iv5 = iv; or5 = ordy;
      x.e = e; x.n = n;
      q5.push_back(x);
    end
  endtask

  always @(negedge ph1) begin
    exp_t x;
    logic [9:0] a;
    cyc++;
    if (q4.size() > 0) begin
      x = q4.pop_front();
      a = {ir4, dc4, 1'b0, mx4, ae4,
           ca4, ol4, ov4, bz4};
      checks++;
      if (a !== x.e) begin
        errors++;
        $display("FAIL n4 %s cyc %0d got %b want %b",
                 x.n, cyc, a, x.e);
      end
    end
    if (q5.size() > 0) begin
      x = q5.pop_front();
      a = {ir5, dc5, mx5, ae5,
           ca5, ol5, ov5, bz5};
      checks++;
      if (a !== x.e) begin
        errors++;
        $display("FAIL n5 %s cyc %0d got %b want %b",
                 x.n, cyc, a, x.e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc %0d got running want done",
             cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // Plain single sample on the 4-tap unit with
  // out_ready high and an empty output slot.
  task automatic single4(input string n);
    step(0, 1, 1, 1, E(1,1,0,0,0,0,0,0), n);
    step(0, 1, 0, 1, E(0,0,0,1,1,0,0,1), n);
    step(0, 1, 0, 1, E(0,0,1,1,0,0,0,1), n);
    step(0, 1, 0, 1, E(0,0,2,1,0,0,0,1), n);
    step(0, 1, 0, 1, E(0,0,3,1,0,0,0,1), n);
    step(0, 1, 0, 1, E(0,0,0,0,0,1,0,1), n);
    step(0, 1, 0, 1, E(1,0,0,0,0,0,1,0), n);
    step(0, 1, 0, 1, E(1,0,0,0,0,0,0,0), n);
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 1, E(0,0,0,0,0,0,0,0), "rst");
    step(0, 1, 0, 1, E(1,0,0,0,0,0,0,0), "rel");

    single4("single");

    for (int s = 0; s < 3; s++) begin
      step(0, 1, 1, 1,
           E(1,1,0,0,0,0,(s > 0),0), "b2b_fire");
      step(0, 1, 1, 1, E(0,0,0,1,1,0,0,1), "b2b");
      for (int t = 1; t < 4; t++)
        step(0, 1, 1, 1,
             E(0,0,3'(t),1,0,0,0,1), "b2b");
      step(0, 1, 1, 1, E(0,0,0,0,0,1,0,1), "b2b_cap");
    end
    step(0, 1, 0, 1, E(1,0,0,0,0,0,1,0), "b2b_end");
    step(0, 1, 0, 1, E(1,0,0,0,0,0,0,0), "b2b_end");

    // Backpressure: two samples, out_ready low.
    step(0, 1, 1, 0, E(1,1,0,0,0,0,0,0), "bp");
    step(0, 1, 0, 0, E(0,0,0,1,1,0,0,1), "bp");
    step(0, 1, 0, 0, E(0,0,1,1,0,0,0,1), "bp");
    step(0, 1, 0, 0, E(0,0,2,1,0,0,0,1), "bp");
    step(0, 1, 0, 0, E(0,0,3,1,0,0,0,1), "bp");
    step(0, 1, 0, 0, E(0,0,0,0,0,1,0,1), "bp_cap1");
    step(0, 1, 1, 0, E(1,1,0,0,0,0,1,0), "bp_fire2");
    step(0, 1, 1, 0, E(0,0,0,1,1,0,1,1), "bp_ign");
    step(0, 1, 1, 0, E(0,0,1,1,0,0,1,1), "bp_ign");
    step(0, 1, 1, 0, E(0,0,2,1,0,0,1,1), "bp_ign");
    step(0, 1, 1, 0, E(0,0,3,1,0,0,1,1), "bp_ign");
    step(0, 1, 1, 0, E(0,0,0,0,0,0,1,1), "bp_stall");
    step(0, 1, 1, 0, E(0,0,0,0,0,0,1,1), "bp_stall");
    step(0, 1, 0, 1, E(0,0,0,0,0,1,1,1), "bp_rel");
    step(0, 1, 1, 0, E(1,1,0,0,0,0,1,0), "bp_keep");

    // Reset while muxControl would be 2.
    step(0, 1, 0, 0, E(0,0,0,1,1,0,1,1), "mid");
    step(0, 1, 0, 0, E(0,0,1,1,0,0,1,1), "mid");
    step(0, 0, 0, 0, E(0,0,0,0,0,0,0,0), "mid_rst");
    step(0, 1, 0, 0, E(1,0,0,0,0,0,0,0), "mid_idle");
    single4("after_rst");

    // 5-tap unit; 4-tap unit left idle.
    step(1, 1, 0, 1, E(1,0,0,0,0,0,0,0), "n5_rel");
    step(1, 1, 1, 1, E(1,1,0,0,0,0,0,0), "n5_fire");
    step(1, 1, 0, 1, E(0,0,0,1,1,0,0,1), "n5_run");
    for (int t = 1; t < 5; t++)
      step(1, 1, 0, 1,
           E(0,0,3'(t),1,0,0,0,1), "n5_run");
    step(1, 1, 0, 1, E(0,0,0,0,0,1,0,1), "n5_cap");
    step(1, 1, 0, 1, E(1,0,0,0,0,0,1,0), "n5_ov");
    step(1, 1, 0, 1, E(1,0,0,0,0,0,0,0), "n5_end");

    @(negedge ph1);
    @(negedge ph1);
    checks++;
    if (q4.size() + q5.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0",
               q4.size() + q5.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
